// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - ALU operation/flag types, sequencer states and wait-state constants
package types;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_ROL  = 4'd5,
    ALU_OP_ROR  = 4'd6,
    ALU_OP_MUL  = 4'd7,
    ALU_OP_MULU = 4'd8
  } alu_operation_e;

  typedef struct packed {
    logic cy;
    logic ac;
    logic v;
    logic z;
    logic s;
  } flags_t;

  typedef enum logic [1:0] {
    ALU_SEQ_IDLE = 2'd0,
    ALU_SEQ_EXEC = 2'd1,
    ALU_SEQ_WAIT = 2'd2,
    ALU_SEQ_RESP = 2'd3
  } alu_seq_state_e;

  localparam logic [5:0] MUL_EXTRA_W = 6'd3;
  localparam logic [5:0] MUL_EXTRA_B = 6'd2;

  // Fixed multiplier penalty on top of whatever the datapath reports.
  function automatic logic [5:0] alu_base_extra(alu_operation_e op, bit wide);
    if (op == ALU_OP_MUL || op == ALU_OP_MULU) begin
      return wide ? MUL_EXTRA_W : MUL_EXTRA_B;
    end
    return 6'd0;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response channel between the microsequencer and alu_seq
interface alu_seq_if;
  import types::*;

  logic           req_valid;
  logic           req_ready;
  alu_operation_e req_op;
  logic [15:0]    req_ta;
  logic [15:0]    req_tb;
  logic           req_wide;
  flags_t         req_flags;
  logic           abort;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [31:0]    rsp_result;
  flags_t         rsp_flags;
  logic           busy;

  modport master (
    output req_valid, req_op, req_ta, req_tb, req_wide, req_flags, abort, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, busy
  );

  modport slave (
    input  req_valid, req_op, req_ta, req_tb, req_wide, req_flags, abort, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, busy
  );

endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registers operands onto the alu, inserts wait states, returns result/flags
// ALU_SEQ_CYCLE_ACCURATE_EN enables the wait-state counter; undefined, every op answers right after EXEC.
module alu_seq
  import types::*;
#(
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_seq_if.slave       bus,
  output alu_operation_e alu_operation,
  output logic [15:0]    alu_ta,
  output logic [15:0]    alu_tb,
  output logic           alu_wide,
  output flags_t         alu_flags_in,
  input  logic [31:0]    alu_result,
  input  logic [5:0]     alu_cycles,
  input  flags_t         alu_flags
);

  alu_seq_state_e   state_q, state_d;
  alu_operation_e   op_q, op_d;
  logic [15:0]      ta_q, ta_d;
  logic [15:0]      tb_q, tb_d;
  logic             wide_q, wide_d;
  flags_t           flags_in_q, flags_in_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  flags_t           rsp_flags_q, rsp_flags_d;
  logic [CNT_W-1:0] wait_w;
  logic             cnt_done;

`ifdef ALU_SEQ_CYCLE_ACCURATE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Zero-extended sum that simply wraps at CNT_W bits; alu_cycles only matters in EXEC.
  assign wait_w   = CNT_W'(alu_base_extra(op_q, wide_q)) + CNT_W'(alu_cycles);
  assign cnt_done = (cnt_q == CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      ALU_SEQ_EXEC: cnt_d = wait_w;
      ALU_SEQ_WAIT: cnt_d = cnt_q - CNT_W'(1);
      default:      cnt_d = cnt_q;
    endcase
    if (bus.abort && (state_q != ALU_SEQ_IDLE)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_alu_cycles;

  assign wait_w            = '0;
  assign cnt_done          = 1'b1;
  assign unused_alu_cycles = ^alu_cycles;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ta_d         = ta_q;
    tb_d         = tb_q;
    wide_d       = wide_q;
    flags_in_d   = flags_in_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      ALU_SEQ_IDLE: begin
        if (bus.req_valid) begin
          op_d       = bus.req_op;
          ta_d       = bus.req_ta;
          tb_d       = bus.req_tb;
          wide_d     = bus.req_wide;
          flags_in_d = bus.req_flags;
          state_d    = ALU_SEQ_EXEC;
        end
      end
      ALU_SEQ_EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        state_d      = (wait_w == '0) ? ALU_SEQ_RESP : ALU_SEQ_WAIT;
      end
      ALU_SEQ_WAIT: begin
        if (cnt_done) begin
          state_d = ALU_SEQ_RESP;
        end
      end
      ALU_SEQ_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ALU_SEQ_IDLE;
        end
      end
      default: state_d = ALU_SEQ_IDLE;
    endcase
    // Abort drops the in-flight op; in IDLE it must not block a new request.
    if (bus.abort && (state_q != ALU_SEQ_IDLE)) begin
      state_d = ALU_SEQ_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ALU_SEQ_IDLE;
      op_q         <= ALU_OP_ADD;
      ta_q         <= '0;
      tb_q         <= '0;
      wide_q       <= 1'b0;
      flags_in_q   <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ta_q         <= ta_d;
      tb_q         <= tb_d;
      wide_q       <= wide_d;
      flags_in_q   <= flags_in_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_operation  = op_q;
  assign alu_ta         = ta_q;
  assign alu_tb         = tb_q;
  assign alu_wide       = wide_q;
  assign alu_flags_in   = flags_in_q;

  assign bus.req_ready  = (state_q == ALU_SEQ_IDLE);
  assign bus.busy       = (state_q != ALU_SEQ_IDLE);
  assign bus.rsp_valid  = (state_q == ALU_SEQ_RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomized checks of alu_seq against a behavioural model
module tb_alu_seq;
  import types::*;

  typedef struct packed {
    logic [31:0] result;
    logic [5:0]  cycles;
    flags_t      flags;
  } alu_out_t;

  logic           clk = 1'b0;
  logic           reset_n;
  alu_operation_e alu_operation;
  logic [15:0]    alu_ta, alu_tb;
  logic           alu_wide;
  flags_t         alu_flags_in;
  alu_out_t       alu_o;
  int             checks = 0;
  int             errors = 0;
  logic [31:0]    res;
  flags_t         fl;

  alu_seq_if bus();

  alu_seq #(.CNT_W(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .alu_operation(alu_operation),
    .alu_ta       (alu_ta),
    .alu_tb       (alu_tb),
    .alu_wide     (alu_wide),
    .alu_flags_in (alu_flags_in),
    .alu_result   (alu_o.result),
    .alu_cycles   (alu_o.cycles),
    .alu_flags    (alu_o.flags)
  );

  always #5 clk = ~clk;

  function automatic alu_out_t alu_model(input alu_operation_e op, input logic [15:0] a,
                                         input logic [15:0] b, input logic w);
    alu_out_t    o;
    logic [16:0] s;
    logic [15:0] r, m;
    logic [31:0] p;
    o = '0;
    m = w ? 16'hFFFF : 16'h00FF;
    r = '0;
    s = '0;
    p = '0;
    case (op)
      ALU_OP_ADD: begin
        s = {1'b0, a & m} + {1'b0, b & m};
        r = s[15:0] & m;
        o.flags.cy = w ? s[16] : s[8];
        o.flags.ac = (int'(a[3:0]) + int'(b[3:0])) > 15;
      end
      ALU_OP_SUB: begin
        s = {1'b0, a & m} - {1'b0, b & m};
        r = s[15:0] & m;
        o.flags.cy = w ? s[16] : s[8];
        o.flags.ac = a[3:0] < b[3:0];
      end
      ALU_OP_AND: r = a & b & m;
      ALU_OP_OR:  r = (a | b) & m;
      ALU_OP_XOR: r = (a ^ b) & m;
      ALU_OP_ROL: begin
        r = a & m;
        for (int i = 0; i < int'(b[4:0]); i++) r = w ? {r[14:0], r[15]} : {8'h00, r[6:0], r[7]};
        o.cycles = {1'b0, b[4:0]};
        o.flags.cy = r[0];
      end
      ALU_OP_ROR: begin
        r = a & m;
        for (int i = 0; i < int'(b[4:0]); i++) r = w ? {r[0], r[15:1]} : {8'h00, r[0], r[7:1]};
        o.cycles = {1'b0, b[4:0]};
        o.flags.cy = w ? r[15] : r[7];
      end
      default: begin
        if (w) p = (op == ALU_OP_MUL) ? {{16{a[15]}}, a} * {{16{b[15]}}, b} : {16'h0, a} * {16'h0, b};
        else   p = (op == ALU_OP_MUL) ? {16'h0, 16'({{8{a[7]}}, a[7:0]} * {{8{b[7]}}, b[7:0]})}
                                      : {16'h0, 16'({8'h0, a[7:0]} * {8'h0, b[7:0]})};
        if (op == ALU_OP_MUL) o.flags.v = w ? (p[31:16] != {16{p[15]}}) : (p[15:8] != {8{p[7]}});
        else                  o.flags.v = w ? (p[31:16] != 16'h0) : (p[15:8] != 8'h0);
        o.flags.cy = o.flags.v;
      end
    endcase
    if (op == ALU_OP_MUL || op == ALU_OP_MULU) begin
      o.result  = p;
      o.flags.z = (p == 32'h0);
      o.flags.s = w ? p[31] : p[15];
    end else begin
      o.result  = {16'h0, r};
      o.flags.z = (r == 16'h0);
      o.flags.s = w ? r[15] : r[7];
    end
    return o;
  endfunction

  always_comb alu_o = alu_model(alu_operation, alu_ta, alu_tb, alu_wide);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input alu_operation_e op, input logic [15:0] a, input logic [15:0] b,
                           input logic w);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_ta    = a;
    bus.req_tb    = b;
    bus.req_wide  = w;
    bus.req_flags = '0;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_op(input alu_operation_e op, input logic [15:0] a, input logic [15:0] b,
                        input logic w, input flags_t fi, input int stall, input logic with_abort,
                        output logic [31:0] r_o, output flags_t f_o);
    alu_out_t e;
    int       ew;
    int       n;
    e  = alu_model(op, a, b, w);
    ew = 0;
`ifdef ALU_SEQ_CYCLE_ACCURATE_EN
    ew = int'(e.cycles) + ((op == ALU_OP_MUL || op == ALU_OP_MULU) ? (w ? 3 : 2) : 0);
`endif
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_ta    = a;
    bus.req_tb    = b;
    bus.req_wide  = w;
    bus.req_flags = fi;
    bus.abort     = with_abort;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.req_op    = alu_operation_e'($urandom_range(0, 8));
    bus.req_ta    = ~a;
    bus.req_tb    = ~b;
    bus.req_wide  = ~w;
    bus.req_flags = flags_t'(~fi);
    check("req_ready_busy", bus.req_ready, 0);
    n = 0;
    while (!bus.rsp_valid && n <= 40) begin
      check("busy", bus.busy, 1);
      check("operand_hold", {alu_operation, alu_ta, alu_tb, alu_wide, alu_flags_in}, {op, a, b, w, fi});
      @(negedge clk);
      n++;
    end
    check("latency", n, 1 + ew);
    check("rsp_result", bus.rsp_result, e.result);
    check("rsp_flags", bus.rsp_flags, e.flags);
    r_o = bus.rsp_result;
    f_o = bus.rsp_flags;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags},
            {1'b1, 1'b0, e.result, e.flags});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_release", {bus.rsp_valid, bus.req_ready, bus.busy}, 3'b010);
  endtask

  initial begin
    int n;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = ALU_OP_ADD;
    bus.req_ta    = '0;
    bus.req_tb    = '0;
    bus.req_wide  = 1'b0;
    bus.req_flags = '0;
    bus.abort     = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {bus.rsp_valid, bus.busy, bus.req_ready}, 3'b001);
    check("reset_rsp", {bus.rsp_result, bus.rsp_flags}, 37'h0);
    check("reset_alu", {alu_operation, alu_ta, alu_tb, alu_wide, alu_flags_in}, 42'h0);
    reset_n = 1'b1;

    run_op(ALU_OP_ADD, 16'hFFFF, 16'h0001, 1'b1, '0, 0, 1'b0, res, fl);
    check("add_result", res, 32'h0);
    check("add_cy_z_ac", {fl.cy, fl.z, fl.ac}, 3'b111);

    run_op(ALU_OP_ROL, 16'h8001, 16'h0005, 1'b1, '0, 0, 1'b0, res, fl);
    check("rol_result", res, 32'h0000_0030);

    run_op(ALU_OP_MUL, 16'h0100, 16'h0100, 1'b1, '0, 4, 1'b0, res, fl);
    check("mul_result", res, 32'h0001_0000);
    check("mul_cy_v", {fl.cy, fl.v}, 2'b11);

    run_op(ALU_OP_MULU, 16'h00FF, 16'h00FF, 1'b0, '0, 1, 1'b0, res, fl);
    check("mulu_byte", res, 32'h0000_FE01);

    run_op(ALU_OP_ADD, 16'h0012, 16'h0034, 1'b0, '0, 0, 1'b1, res, fl);
    check("abort_idle_accept", res, 32'h46);

    start_req(ALU_OP_ROL, 16'h1234, 16'd10, 1'b1);
`ifdef ALU_SEQ_CYCLE_ACCURATE_EN
    repeat (3) begin
      @(negedge clk);
      check("abort_wait_busy", {bus.rsp_valid, bus.busy}, 2'b01);
    end
`endif
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_to_idle", {bus.rsp_valid, bus.req_ready, bus.busy}, 3'b010);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", {bus.rsp_valid, bus.busy}, 2'b00);
    end
    run_op(ALU_OP_ADD, 16'h0005, 16'h0007, 1'b1, '0, 0, 1'b0, res, fl);
    check("add_after_abort", res, 32'hC);

    start_req(ALU_OP_XOR, 16'h00F0, 16'h00FF, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_reached", bus.rsp_valid, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_resp", {bus.rsp_valid, bus.req_ready}, 2'b01);

    start_req(ALU_OP_ROL, 16'hABCD, 16'd20, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_ctrl", {bus.rsp_valid, bus.busy, bus.req_ready}, 3'b001);
    check("midrst_rsp", {bus.rsp_result, bus.rsp_flags}, 37'h0);
    check("midrst_alu", {alu_operation, alu_ta, alu_tb, alu_wide, alu_flags_in}, 42'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {bus.req_ready, bus.busy}, 2'b10);

    run_op(ALU_OP_ROL, 16'h8001, 16'h0005, 1'b1, '0, 0, 1'b0, res, fl);
    check("rol_after_rst", res, 32'h0000_0030);

    for (int i = 0; i < 40; i++) begin
      run_op(alu_operation_e'($urandom_range(0, 8)), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), flags_t'($urandom_range(0, 31)),
             int'($urandom_range(0, 2)), 1'b0, res, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencer wrapping the combinational `alu` datapath. It accepts one operation at a time over a valid/ready request channel and registers the operands onto the ALU inputs. It inserts the wait states the operation costs: a per-operation base penalty plus the ALU-reported `alu_cycles` count. It then presents result and flags on a valid/ready response channel. The block sits between the execution-unit microsequencer and `alu`, and gives the core cycle-accurate ALU timing.

## Interface
Parameters:
- `CNT_W`, 6: width of the wait-state counter. The maximum wait is 31 + `MUL_EXTRA_W` = 34, so 6 bits suffices.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  `alu_operation_e`  operation.
- `req_ta`, `req_tb`  in  16  operands.
- `req_wide`  in  1  1 = 16-bit, 0 = 8-bit.
- `req_flags`  in  `flags_t`  input flags.
- `abort`  in  1  flush the in-flight operation.
- `alu_operation`  out  `alu_operation_e`  registered op to `alu`.
- `alu_ta`, `alu_tb`  out  16  registered operands.
- `alu_wide`  out  1  registered width.
- `alu_flags_in`  out  `flags_t`  registered flags.
- `alu_result`  in  32  from `alu`.
- `alu_cycles`  in  6  from `alu`.
- `alu_flags`  in  `flags_t`  from `alu`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_result`  out  32  captured result.
- `rsp_flags`  out  `flags_t`  captured flags.
- `busy`  out  1  state != IDLE.

## Operation
States: IDLE, EXEC, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch op, operands, width and flags into the `alu_*` registers, then go to EXEC.
- **EXEC** (one cycle)
  - ALU outputs are valid combinationally from the registered inputs.
  - Capture `alu_result` and `alu_flags` into the `rsp_*` registers.
  - Compute `wait = base_extra(op, wide) + alu_cycles`.
  - If `wait` = 0, go to RESP. Otherwise load the counter with `wait` and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1 (it reads 0 on exit), go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_result` and `rsp_flags` are held stable.
  - On `rsp_ready`, go to IDLE.
  - No new request is accepted in the same cycle.
- **base_extra** (package constants)
  - MUL and MULU: `MUL_EXTRA_W`=3 when wide, `MUL_EXTRA_B`=2 otherwise.
  - All other ops: 0.
- **Arithmetic**
  - The counter adds zero-extended values, with no saturation.
  - `alu_cycles` is sampled only in EXEC.
- **abort**
  - Sampled in EXEC, WAIT or RESP: next state is IDLE and `rsp_valid` drops next cycle. The response is discarded.
  - Ignored in IDLE. If `abort` and `req_valid` are both high in IDLE, the request is accepted.
- **Reset** (`reset_n`=0 at a clock edge, from any state)
  - State goes to IDLE and the counter to 0.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0.
  - `alu_operation`=ALU_OP_ADD, `alu_ta`=`alu_tb`=0, `alu_wide`=0, `alu_flags_in`=0.
  - `busy`=0; `req_ready`=1 from the first cycle after reset.
- **Operand hold**: the `alu_*` registers change only on request acceptance, never during WAIT or RESP.

## Timing
- Request accepted at edge T (`req_valid`&`req_ready`). EXEC occupies cycle T+1.
- `rsp_valid` first high in cycle T+2+`wait`.
- Throughput: one operation per 3+`wait` cycles at best, because IDLE is revisited between operations.
- `req_ready` is combinational from the state register only. There is no combinational path from `req_valid` to `req_ready`.
- `rsp_*` outputs are registered.

## Configuration
`ALU_SEQ_CYCLE_ACCURATE_EN`:
- Defined: wait states exactly as above.
- Undefined: `wait` is forced to 0. Every op responds at T+2, WAIT is unreachable, and the counter logic is removed.
- Results and flags are identical in both modes.

## Structure
- Package `types`: add `alu_seq_state_e` (IDLE/EXEC/WAIT/RESP) and the constants `MUL_EXTRA_W` and `MUL_EXTRA_B`.
- Put the function `alu_base_extra(alu_operation_e, bit wide)` in the same package.
- No sub-module. `alu` is instantiated by the parent, not inside `alu_seq`.

## Test plan
- ADD wide, ta=0xFFFF, tb=0x0001, `ALU_SEQ_CYCLE_ACCURATE_EN` defined -> `rsp_valid` at T+2, result 0x0000, CY=1, Z=1, AC=1.
- ROL wide, ta=0x8001, tb=5 (`alu_cycles`=5) -> `rsp_valid` at T+7, result 0x0030, `busy` high T+1..T+7.
- MUL wide, ta=0x0100, tb=0x0100 -> `rsp_valid` at T+5, result 0x00010000, CY=V=1.
- Backpressure: hold `rsp_ready`=0 for 4 cycles in RESP -> `rsp_*` stable, `req_ready`=0; release gives IDLE the next cycle.
- `abort` in WAIT of ROL with tb=10 -> IDLE next cycle, `rsp_valid` never asserted; the next ADD completes at T+2.
- `reset_n`=0 mid-WAIT -> all outputs at reset values next cycle, `req_ready`=1 after reset release. With the macro undefined, the ROL with tb=5 responds at T+2 with the same result.
